// File: rtl/trencadis_pulse_train_pkg.sv
// Shared types for the trencadis multi-channel pulse train generator.
package trencadis_pulse_train_pkg;

  // Channel operating mode, as presented on mode_i.
  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  // Per-channel FSM state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Map the raw mode_i bit onto the mode enumeration.
  function automatic mode_e decode_mode(input logic mode_bit);
    return mode_bit ? MODE_ONESHOT : MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/trencadis_pulse_train_channel.sv
// One pulse generator channel: IDLE/RUN FSM, phase counter and shadow
// copies of period, width and mode. The shadows only change when a period
// starts, so reprogramming the inputs never produces a truncated pulse.
// All outputs are registered and reflect the state entered on the edge.
module trencadis_pulse_train_channel
  import trencadis_pulse_train_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             trig_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign mode_in = decode_mode(mode_i);

  // Next-state logic: start, count, wrap/reload, one-shot end, disable.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    wid_d   = wid_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A zero period never starts, so the output cannot stick high.
        if (en_i && (period_i != '0) &&
            ((mode_in == MODE_PERIODIC) || trig_i)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          per_d   = period_i;
          wid_d   = width_i;
          mode_d  = mode_in;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          // Disable is immediate and silent: no done strobe.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == per_q) begin
          if (mode_q == MODE_ONESHOT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = '0;
            per_d  = period_i;
            wid_d  = width_i;
            mode_d = mode_in;
          end
        end else if (sync_i && (mode_q == MODE_PERIODIC)) begin
          // Phase alignment behaves exactly like an early period boundary.
          cnt_d  = '0;
          per_d  = period_i;
          wid_d  = width_i;
          mode_d = mode_in;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs describe the state being entered so they line up with it.
    busy_d  = (state_d == ST_RUN);
    pulse_d = (state_d == ST_RUN) && (cnt_d < wid_d);
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PERIODIC;
      cnt_q   <= '0;
      per_q   <= '0;
      wid_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/trencadis_pulse_train_generator.sv
// Multi-channel programmable pulse train generator. Each channel emits a
// pulse of width_i cycles once every period_i+1 cycles, periodically or as
// a triggered one-shot. The top only slices the packed buses per channel.
// Optional feature: define TRENCADIS_PULSEGEN_SYNC_EN to add sync_i, which
// restarts the phase of every running periodic channel.
module trencadis_pulse_train_generator
  import trencadis_pulse_train_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
`ifdef TRENCADIS_PULSEGEN_SYNC_EN
  input  logic                      sync_i,
`endif
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       trig_i,
  input  logic [CHANNELS*CNT_W-1:0] period_i,
  input  logic [CHANNELS*CNT_W-1:0] width_i,
  output logic [CHANNELS-1:0]       pulse_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS-1:0]       done_o
);

  logic sync_w;

`ifdef TRENCADIS_PULSEGEN_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    trencadis_pulse_train_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[g]),
      .mode_i   (mode_i[g]),
      .trig_i   (trig_i[g]),
      .sync_i   (sync_w),
      .period_i (period_i[g*CNT_W +: CNT_W]),
      .width_i  (width_i[g*CNT_W +: CNT_W]),
      .pulse_o  (pulse_o[g]),
      .busy_o   (busy_o[g]),
      .done_o   (done_o[g])
    );
  end

endmodule

// File: tb/tb_trencadis_pulse_train_generator.sv
// Bench for trencadis_pulse_train_generator: directed scenarios followed by
// randomized traffic, every cycle compared against a timestamp-based model.
module tb_trencadis_pulse_train_generator;

  localparam int CH = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              sync;
  logic [CH-1:0]     en, mode, trig;
  logic [CW-1:0]     per [CH];
  logic [CW-1:0]     wid [CH];
  logic [CH*CW-1:0]  period_bus, width_bus;
  logic [CH-1:0]     pulse, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a running channel remembers the cycle its current
  // period started; the phase is simply elapsed cycles since then.
  bit            m_run [CH];
  int            m_seg [CH];
  int            m_P   [CH];
  int            m_W   [CH];
  bit            m_M   [CH];
  logic [CH-1:0] e_pulse, e_busy, e_done;
  int            cyc;

  always #5 clk = ~clk;

  always_comb begin
    period_bus = '0;
    width_bus  = '0;
    for (int i = 0; i < CH; i++) begin
      period_bus[i*CW +: CW] = per[i];
      width_bus[i*CW +: CW]  = wid[i];
    end
  end

  trencadis_pulse_train_generator #(
    .CHANNELS (CH),
    .CNT_W    (CW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
`ifdef TRENCADIS_PULSEGEN_SYNC_EN
    .sync_i   (sync),
`endif
    .en_i     (en),
    .mode_i   (mode),
    .trig_i   (trig),
    .period_i (period_bus),
    .width_i  (width_bus),
    .pulse_o  (pulse),
    .busy_o   (busy),
    .done_o   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_seg[c] = 0; m_P[c] = 0; m_W[c] = 0; m_M[c] = 0;
    end
    e_pulse = '0; e_busy = '0; e_done = '0;
  endtask

  task automatic model_load(input int c);
    m_seg[c] = cyc;
    m_P[c]   = int'(per[c]);
    m_W[c]   = int'(wid[c]);
    m_M[c]   = mode[c];
  endtask

  task automatic model_edge();
`ifdef TRENCADIS_PULSEGEN_SYNC_EN
    bit s = sync;
`else
    bit s = 1'b0;
`endif
    cyc++;
    for (int c = 0; c < CH; c++) begin
      e_done[c] = 1'b0;
      if (!m_run[c]) begin
        if (en[c] && per[c] != 0 && (!mode[c] || trig[c])) begin
          m_run[c] = 1;
          model_load(c);
        end
      end else begin
        int elapsed = cyc - 1 - m_seg[c];
        if (!en[c]) m_run[c] = 0;
        else if (elapsed == m_P[c]) begin
          if (m_M[c]) begin m_run[c] = 0; e_done[c] = 1'b1; end
          else model_load(c);
        end else if (s && !m_M[c]) model_load(c);
      end
      e_busy[c]  = m_run[c];
      e_pulse[c] = m_run[c] && ((cyc - m_seg[c]) < m_W[c]);
    end
  endtask

  // One clock: model consumes the inputs the DUT samples, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("pulse", pulse, e_pulse);
    check_eq("busy",  busy,  e_busy);
    check_eq("done",  done,  e_done);
  endtask

  task automatic set_ch(input int c, input bit e, input bit m, input int p, input int w);
    en[c] = e; mode[c] = m; per[c] = CW'(p); wid[c] = CW'(w);
  endtask

  initial begin
    logic [9:0]  seq10;
    logic [11:0] seq12;
    int bcnt, pcnt, dcnt, mis;
    logic acc_or, acc_and;
    bit found;

    // 1. Reset with all channels enabled and programmed.
    rst_ni = 1'b0; sync = 1'b0; trig = '0;
    for (int c = 0; c < CH; c++) set_ch(c, 1, 0, 4, 2);
    model_reset();
    #12;
    check_eq("rst_pulse", pulse, 0);
    check_eq("rst_busy",  busy,  0);
    check_eq("rst_done",  done,  0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    #2;
    check_eq("post_rst_pulse", pulse, 0);
    check_eq("post_rst_busy",  busy,  0);

    // 2. Periodic period=4 width=2: 2 high, 3 low, repeating.
    seq10 = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) check_eq("first_pulse", pulse, 4'hF);
      seq10 = {seq10[8:0], pulse[0]};
    end
    check_eq("ch0_pattern", seq10, 10'b1100011000);

    en = '0;
    step(); step();

    // 3. One-shot on ch1 with a retrigger attempt while busy.
    set_ch(1, 1, 1, 3, 1);
    bcnt = 0; pcnt = 0; dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      trig[1] = (i == 0 || i == 2);
      step();
      bcnt += busy[1]; pcnt += pulse[1]; dcnt += done[1];
    end
    trig = '0;
    check_eq("os_busy_cnt",  bcnt, 4);
    check_eq("os_pulse_cnt", pcnt, 1);
    check_eq("os_done_cnt",  dcnt, 1);
    en = '0;
    step();

    // 4. period=0 (with trigger) and width=0 never pulse; width>period is 100%.
    set_ch(2, 1, 0, 0, 5); trig[2] = 1'b1;
    set_ch(3, 1, 0, 4, 0);
    acc_or = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); acc_or |= pulse[2] | pulse[3]; end
    check_eq("zero_no_pulse", acc_or, 1'b0);
    check_eq("per0_idle", busy[2], 1'b0);
    en = '0; trig = '0;
    step();
    set_ch(0, 1, 0, 4, 10);
    acc_and = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); acc_and &= pulse[0]; end
    check_eq("full_duty", acc_and, 1'b1);
    en = '0;
    step();

    // 5. Period change 4 -> 2 mid-period, then disable mid-pulse.
    set_ch(0, 1, 0, 4, 1);
    seq12 = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) per[0] = CW'(2);
      step();
      seq12 = {seq12[10:0], pulse[0]};
    end
    check_eq("per_change", seq12, 12'b100001001001);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin step(); found = pulse[0]; end
    check_eq("wait_pulse", found, 1'b1);
    en[0] = 1'b0;
    step();
    check_eq("drop_pulse", pulse[0], 1'b0);
    check_eq("drop_busy",  busy[0],  1'b0);
    check_eq("drop_done",  done[0],  1'b0);
    step();

`ifdef TRENCADIS_PULSEGEN_SYNC_EN
    // 6. Two periodic channels started 3 cycles apart, realigned by sync.
    set_ch(0, 1, 0, 7, 2);
    set_ch(1, 0, 0, 7, 2);
    step(); step(); step();
    en[1] = 1'b1;
    step(); step();
    sync = 1'b1;
    mis = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      sync = 1'b0;
      if (pulse[0] != pulse[1]) mis++;
    end
    check_eq("sync_align", mis, 0);
    en = '0;
    step();
`endif

    // 7. Randomized traffic on all channels.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        en[c]   = ($urandom_range(0, 15) != 0);
        trig[c] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) mode[c] = $urandom_range(0, 1);
        if ($urandom_range(0, 5) == 0) per[c]  = CW'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) wid[c]  = CW'($urandom_range(0, 12));
      end
`ifdef TRENCADIS_PULSEGEN_SYNC_EN
      sync = ($urandom_range(0, 15) == 0);
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
